dcf_marquee_scroller: RTL and testbench
=======================================

Name: dcf_marquee_scroller

Overview:
- Parametrised scrolling display register for the DCF77 clock front panel.
- Holds a frame of BCD/glyph nibbles (time, spaces, date with dash separators) loaded in parallel by the decoder.
- Presents a WIN-digit window to the 7-segment driver.
- Window scrolls left, right, bounces, or stays static. One nibble moves per step strobe, with a programmable dwell at the frame origin and at the bounce ends.

Parameters:
- DIGITS, 20, frame length in nibbles (≥ WIN+1).
- WIN, 4, displayed digits.
- IDXW, 5, position/index width, ≥ clog2(DIGITS).
- PAUSE, 3, step strobes held at origin/ends before movement resumes (0 = no dwell).

Ports:
- qzt_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture frame_in this cycle.
- frame_in  in  4*DIGITS  digit 0 = frame_in[4*DIGITS-1 -: 4], digit k at next-lower nibble.
- step  in  1  single-cycle scroll strobe (scroll rate tick).
- mode  in  2  00 static, 01 scroll left, 10 scroll right, 11 bounce.
- static_pos  in  IDXW  window offset used in static mode.
- display_buffer  out  4*WIN  window; MS nibble = digit pos, then pos+1 … mod DIGITS.
- pos  out  IDXW  current window offset, 0..DIGITS-1.
- wrap  out  1  one-cycle pulse when scroll wraps or bounce reverses.

Behaviour:
- Reset (sync, rst=1 at edge):
  - all frame nibbles = 4'hA (blank); display_buffer = all 4'hA.
  - pos=0, dwell=0, dir=left, wrap=0.
  - rst has priority over everything.
- display_buffer is registered. It reflects frame/pos one cycle after they change (latency 1 from load or step edge).
- Load (priority over step in the same cycle):
  - frame <= frame_in.
  - pos <= 0 (static mode: clamped static_pos); dwell <= PAUSE; dir <= left.
  - wrap not asserted.
- Static (mode=00):
  - pos <= min(static_pos, DIGITS-1) every cycle; step ignored.
  - dwell is held at its current value.
- Scroll left (01), on step:
  - if dwell>0: dwell--, pos unchanged.
  - else pos <= (pos+1) mod DIGITS.
  - On the step that takes pos DIGITS-1 → 0: dwell <= PAUSE and wrap=1 next cycle.
- Scroll right (10), on step:
  - if dwell>0: dwell--.
  - else pos <= (pos-1) mod DIGITS (0 → DIGITS-1).
  - On the step reaching 0: dwell <= PAUSE, wrap pulse.
- Bounce (11): travel range is 0..DIGITS-WIN. On step:
  - dwell>0: dwell--.
  - pos > DIGITS-WIN (entered from another mode): pos <= DIGITS-WIN, dir <= right, no wrap.
  - dir=left, pos < DIGITS-WIN: pos++.
  - dir=left, pos = DIGITS-WIN: dir <= right, dwell <= PAUSE, wrap pulse, pos unchanged.
  - dir=right, pos > 0: pos--.
  - dir=right, pos = 0: dir <= left, dwell <= PAUSE, wrap pulse.
- Mode change mid-scroll:
  - pos and dwell are retained; the new rule applies from the next step.
  - Leaving bounce leaves dir as is; dir is ignored outside bounce.
- Window addressing: index arithmetic is modulo DIGITS (not 2^IDXW), so the window wraps seamlessly (e.g. pos=DIGITS-1 shows digit DIGITS-1 then 0,1,2).
- step held high several cycles is treated as one step per cycle (no edge detection; the tick source guarantees single-cycle strobes).
- No behaviour depends on the nibble values; glyph decoding is downstream.

Decomposition:
- Package dcf_display_pkg:
  - MODE_STATIC/LEFT/RIGHT/BOUNCE 2-bit constants.
  - BLANK_NIBBLE=4'hA, DASH_NIBBLE=4'hB (shared with the frame builder and segment decoder).
- Sub-module nibble_window_mux(DIGITS, WIN, IDXW): combinational modulo-indexed selection of WIN nibbles from the frame at offset pos. Top-level registers its output.
- Top-level holds the frame register, pos/dwell/dir state and mode sequencing.

Test Plan (DIGITS=8, WIN=4, PAUSE=1 unless stated; frame_in=32'h01234567):
- Reset then idle: display_buffer=16'hAAAA, pos=0, wrap=0. Load in mode 01: next cycle display_buffer=16'h0123, pos=0.
- Mode 01, 9 steps after load:
  - step1 is the dwell step, display stays 0123.
  - steps 2–8 give 1234, 2345, …, 7012 (pos 1..7).
  - step 9 gives pos=0, 0123, wrap=1 for exactly one cycle.
- Mode 10, PAUSE=0, one step after load: pos=7, display=16'h7012, wrap=0. Next step: pos=6, 6701.
- Mode 11, PAUSE=0, steps from pos 0:
  - pos 1,2,3,4, then reversal step with wrap=1 and pos=4.
  - then pos 3,2,1,0, then reversal with wrap=1.
  - display at pos=4 is 16'h4567.
- Mode 00 with static_pos=6: display=16'h6701 one cycle after pos updates; steps cause no change. static_pos=9 clamps to pos=7.
- Load and step asserted together mid-scroll (pos=5): load wins, pos=0, dwell=1, display=new frame digits 0..3. Assert rst while pos=3: next cycle all 4'hA, pos=0.

Source files
------------

// File: rtl/dcf_display_pkg.sv
// dcf_display_pkg: scroll modes, direction and glyph codes shared by the front-panel display path
package dcf_display_pkg;
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;
  localparam logic [3:0] BLANK_NIBBLE = 4'hA;
  localparam logic [3:0] DASH_NIBBLE  = 4'hB;
  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;
endpackage

// File: rtl/nibble_window_mux.sv
// nibble_window_mux: picks WIN consecutive nibbles from the frame starting at pos, wrapping modulo DIGITS
module nibble_window_mux
  import dcf_display_pkg::*;
#(
  parameter int DIGITS = 20,
  parameter int WIN    = 4,
  parameter int IDXW   = 5
) (
  input  logic [4*DIGITS-1:0] frame,
  input  logic [IDXW-1:0]     pos,
  output logic [4*WIN-1:0]    window
);
  logic [3:0] nib [2**IDXW];
  for (genvar k = 0; k < 2**IDXW; k++) begin : g_n
    if (k < DIGITS) begin : g_v
      assign nib[k] = frame[4*(DIGITS-1-k) +: 4];
    end else begin : g_b
      assign nib[k] = BLANK_NIBBLE;
    end
  end
  for (genvar i = 0; i < WIN; i++) begin : g_w
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    assign sum = {1'b0, pos} + (IDXW+1)'(i);
    assign idx = (sum >= (IDXW+1)'(DIGITS)) ? IDXW'(sum - (IDXW+1)'(DIGITS)) : IDXW'(sum);
    assign window[4*(WIN-1-i) +: 4] = nib[idx];
  end
endmodule

// File: rtl/dcf_marquee_scroller.sv
// dcf_marquee_scroller: frame register plus scroll/bounce sequencing feeding a registered display window
module dcf_marquee_scroller
  import dcf_display_pkg::*;
#(
  parameter int DIGITS = 20,
  parameter int WIN    = 4,
  parameter int IDXW   = 5,
  parameter int PAUSE  = 3
) (
  input  logic                qzt_clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] frame_in,
  input  logic                step,
  input  logic [1:0]          mode,
  input  logic [IDXW-1:0]     static_pos,
  output logic [4*WIN-1:0]    display_buffer,
  output logic [IDXW-1:0]     pos,
  output logic                wrap
);
  localparam int DWW = $clog2(PAUSE + 2);
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0] TOP  = IDXW'(DIGITS - WIN);
  localparam logic [DWW-1:0]  DWELL = DWW'(PAUSE);
  logic [4*DIGITS-1:0] frame_q, frame_d;
  logic [IDXW-1:0]     pos_q, pos_d, clamp;
  logic [DWW-1:0]      dwell_q, dwell_d;
  dir_e                dir_q, dir_d;
  logic                wrap_q, wrap_d;
  logic [4*WIN-1:0]    disp_q, win;
  assign clamp = (static_pos > LAST) ? LAST : static_pos;
  nibble_window_mux #(.DIGITS(DIGITS), .WIN(WIN), .IDXW(IDXW)) u_mux (
    .frame  (frame_q),
    .pos    (pos_q),
    .window (win)
  );
  // next frame/position/dwell/direction; load beats static tracking beats stepping
  always_comb begin
    frame_d = frame_q;
    pos_d   = pos_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load) begin
      frame_d = frame_in;
      pos_d   = (mode == MODE_STATIC) ? clamp : '0;
      dwell_d = DWELL;
      dir_d   = DIR_LEFT;
    end else if (mode == MODE_STATIC) begin
      pos_d = clamp;
    end else if (step && dwell_q != '0) begin
      dwell_d = dwell_q - 1'b1;
    end else if (step) begin
      case (mode)
        MODE_LEFT: begin
          pos_d  = (pos_q == LAST) ? '0 : pos_q + 1'b1;
          wrap_d = pos_q == LAST;
        end
        MODE_RIGHT: begin
          pos_d  = (pos_q == '0) ? LAST : pos_q - 1'b1;
          wrap_d = pos_q == IDXW'(1);
        end
        default: begin
          if (pos_q > TOP) begin
            pos_d = TOP;
            dir_d = DIR_RIGHT;
          end else if (dir_q == DIR_LEFT) begin
            pos_d  = (pos_q < TOP) ? pos_q + 1'b1 : pos_q;
            dir_d  = (pos_q < TOP) ? DIR_LEFT : DIR_RIGHT;
            wrap_d = pos_q == TOP;
          end else begin
            pos_d  = (pos_q != '0) ? pos_q - 1'b1 : pos_q;
            dir_d  = (pos_q != '0) ? DIR_RIGHT : DIR_LEFT;
            wrap_d = pos_q == '0;
          end
        end
      endcase
      dwell_d = wrap_d ? DWELL : dwell_q;
    end
  end
  // state registers; the window lags frame/pos by one cycle
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      frame_q <= {DIGITS{BLANK_NIBBLE}};
      disp_q  <= {WIN{BLANK_NIBBLE}};
      pos_q   <= '0;
      dwell_q <= '0;
      dir_q   <= DIR_LEFT;
      wrap_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      disp_q  <= win;
      pos_q   <= pos_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end
  assign display_buffer = disp_q;
  assign pos            = pos_q;
  assign wrap           = wrap_q;
endmodule

// File: tb/tb_dcf_marquee_scroller.sv
// tb_dcf_marquee_scroller: two scrollers (PAUSE=1 and PAUSE=0) checked every cycle against a frame/position model plus literal checkpoints
module tb_dcf_marquee_scroller;
  logic        qzt_clk = 1'b0;
  logic        rst = 1'b1, load = 1'b0, step = 1'b0;
  logic [31:0] frame_in = '0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  static_pos = '0;
  logic [15:0] disp [2];
  logic [4:0]  posv [2];
  logic        wrapv [2];
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  always #5 qzt_clk = ~qzt_clk;

  dcf_marquee_scroller #(.DIGITS(8), .WIN(4), .IDXW(5), .PAUSE(0)) u0 (
    .qzt_clk(qzt_clk), .rst(rst), .load(load), .frame_in(frame_in), .step(step),
    .mode(mode), .static_pos(static_pos), .display_buffer(disp[0]), .pos(posv[0]), .wrap(wrapv[0]));
  dcf_marquee_scroller #(.DIGITS(8), .WIN(4), .IDXW(5), .PAUSE(1)) u1 (
    .qzt_clk(qzt_clk), .rst(rst), .load(load), .frame_in(frame_in), .step(step),
    .mode(mode), .static_pos(static_pos), .display_buffer(disp[1]), .pos(posv[1]), .wrap(wrapv[1]));

  int mf [2][8];
  int mp [2], md [2], mdir [2];
  bit mw [2];
  logic [15:0] mdisp [2];

  function automatic logic [15:0] window_of(int q, int p);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r = {r[11:0], 4'(mf[q][(p + i) % 8])};
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: instance q dwells q strobes; window shown is the one for last cycle's frame/pos
  always @(posedge qzt_clk) begin
    for (int q = 0; q < 2; q++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) mf[q][k] = 10;
        mp[q] = 0; md[q] = 0; mdir[q] = 0; mw[q] = 0; mdisp[q] = 16'hAAAA;
      end else begin
        int c;
        c = (static_pos > 7) ? 7 : int'(static_pos);
        mdisp[q] = window_of(q, mp[q]);
        mw[q] = 0;
        if (load) begin
          for (int k = 0; k < 8; k++) mf[q][k] = int'(frame_in[31-4*k -: 4]);
          mp[q] = (mode == 2'b00) ? c : 0;
          md[q] = q; mdir[q] = 0;
        end else if (mode == 2'b00) begin
          mp[q] = c;
        end else if (step) begin
          if (md[q] > 0) md[q]--;
          else if (mode == 2'b01) begin
            mp[q] = (mp[q] + 1) % 8;
            if (mp[q] == 0) begin md[q] = q; mw[q] = 1; end
          end else if (mode == 2'b10) begin
            mp[q] = (mp[q] + 7) % 8;
            if (mp[q] == 0) begin md[q] = q; mw[q] = 1; end
          end else if (mp[q] > 4) begin
            mp[q] = 4; mdir[q] = 1;
          end else if (mdir[q] == 0) begin
            if (mp[q] < 4) mp[q]++;
            else begin mdir[q] = 1; md[q] = q; mw[q] = 1; end
          end else begin
            if (mp[q] > 0) mp[q]--;
            else begin mdir[q] = 0; md[q] = q; mw[q] = 1; end
          end
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge qzt_clk) begin
    if (chk_en) begin
      for (int q = 0; q < 2; q++) begin
        chk($sformatf("model_disp%0d", q), int'(disp[q]), int'(mdisp[q]));
        chk($sformatf("model_pos%0d", q), int'(posv[q]), mp[q]);
        chk($sformatf("model_wrap%0d", q), int'(wrapv[q]), int'(mw[q]));
      end
    end
  end

  task automatic tick();
    @(negedge qzt_clk);
  endtask

  task automatic do_step();
    step = 1'b1; tick(); step = 1'b0; tick();
  endtask

  task automatic do_load(logic [1:0] m, logic [31:0] f);
    mode = m; frame_in = f; load = 1'b1; tick(); load = 1'b0;
  endtask

  int lpos [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int ldisp [9] = '{'h0123, 'h1234, 'h2345, 'h3456, 'h4567, 'h5670, 'h6701, 'h7012, 'h0123};
  int bpos [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
  int bwrap [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0; tick();
    chk("rst_disp", int'(disp[1]), 'hAAAA);
    chk("rst_pos", int'(posv[1]), 0);
    chk("rst_wrap", int'(wrapv[1]), 0);
    // scroll left, PAUSE=1 instance
    do_load(2'b01, 32'h01234567); tick();
    chk("load_disp", int'(disp[1]), 'h0123);
    chk("load_pos", int'(posv[1]), 0);
    for (int k = 0; k < 9; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk($sformatf("left_pos%0d", k + 1), int'(posv[1]), lpos[k]);
      chk($sformatf("left_wrap%0d", k + 1), int'(wrapv[1]), (k == 8) ? 1 : 0);
      tick();
      chk($sformatf("left_disp%0d", k + 1), int'(disp[1]), ldisp[k]);
      chk($sformatf("left_wrapoff%0d", k + 1), int'(wrapv[1]), 0);
    end
    // scroll right, PAUSE=0 instance
    do_load(2'b10, 32'h01234567); tick();
    step = 1'b1; tick(); step = 1'b0;
    chk("right_pos1", int'(posv[0]), 7);
    chk("right_wrap1", int'(wrapv[0]), 0);
    tick();
    chk("right_disp1", int'(disp[0]), 'h7012);
    do_step();
    chk("right_pos2", int'(posv[0]), 6);
    chk("right_disp2", int'(disp[0]), 'h6701);
    // bounce, PAUSE=0 instance
    do_load(2'b11, 32'h01234567); tick();
    for (int k = 0; k < 10; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk($sformatf("bounce_pos%0d", k), int'(posv[0]), bpos[k]);
      chk($sformatf("bounce_wrap%0d", k), int'(wrapv[0]), bwrap[k]);
      tick();
      if (k == 3) chk("bounce_disp4", int'(disp[0]), 'h4567);
    end
    // static
    mode = 2'b00; static_pos = 5'd6; tick();
    chk("static_pos6", int'(posv[0]), 6);
    tick();
    chk("static_disp6", int'(disp[0]), 'h6701);
    do_step(); do_step();
    chk("static_hold", int'(posv[1]), 6);
    static_pos = 5'd9; tick();
    chk("static_clamp", int'(posv[1]), 7);
    // bounce entered above travel range
    mode = 2'b11; step = 1'b1; tick(); step = 1'b0;
    chk("bounce_entry_pos", int'(posv[0]), 4);
    chk("bounce_entry_wrap", int'(wrapv[0]), 0);
    tick(); do_step();
    chk("bounce_entry_dir", int'(posv[0]), 3);
    // load beats step at pos 5, then reset at pos 3
    do_load(2'b01, 32'h01234567); tick();
    for (int k = 0; k < 6; k++) do_step();
    chk("mid_pos5", int'(posv[1]), 5);
    frame_in = 32'hFEDCBA98; load = 1'b1; step = 1'b1; tick();
    load = 1'b0; step = 1'b0;
    chk("ldstep_pos", int'(posv[1]), 0);
    tick();
    chk("ldstep_disp", int'(disp[1]), 'hFEDC);
    do_step();
    chk("ldstep_dwell", int'(posv[1]), 0);
    do_step(); do_step(); do_step();
    chk("pre_rst_pos", int'(posv[1]), 3);
    rst = 1'b1; tick();
    chk("rst2_disp", int'(disp[1]), 'hAAAA);
    chk("rst2_pos", int'(posv[1]), 0);
    rst = 1'b0; tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
